// File: rtl/fft_input_buffer.sv
// ---------------------------------------------------------------------------
// fft_input_buffer
//
// Block input stage for the radix-2 FFT datapath. A block of 2**M signed
// samples is collected over a valid/ready handshake into a single register
// bank. The bank is then drained as (a, b) operand pairs for the first
// butterfly stage. Filling and draining alternate on the one bank and never
// overlap.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds its data and valid stable
// until that edge. Ready never depends combinationally on valid.
//
// Build option:
//   FFT_IBUF_BITREV_EN  defined   -> samples are written at bitrev_M(wcnt),
//                                    giving DIT first-stage pairs
//                                    (x[k], x[k + 2**(M-1)]).
//                       undefined -> samples are written at wcnt (natural
//                                    order), giving pairs (x[2k], x[2k+1]).
//
// Parameters:
//   N  data width is 2**N bits
//   M  log2 of the block length (M >= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   in_data      input sample
//   in_valid     in_data valid
//   in_ready     buffer accepts a sample this cycle (registered)
//   pair_a       butterfly operand a (registered)
//   pair_b       butterfly operand b (registered)
//   pair_valid   pair_a / pair_b valid (registered)
//   pair_ready   downstream consumes the pair this cycle
//   pair_last    current pair is the final pair of the block (registered)
//   o_dbg_state  current FSM state (0 = FILL, 1 = DRAIN)
// ---------------------------------------------------------------------------
module fft_input_buffer #(
    parameter int N = 4,
    parameter int M = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2**N-1:0]   pair_a,
    output logic [2**N-1:0]   pair_b,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic              pair_last,
    output logic              o_dbg_state
);

    localparam int W     = 2**N;
    localparam int DEPTH = 2**M;
    // Pair counter needs M-1 bits; keep at least one bit so M = 1 still builds.
    localparam int RW    = (M > 1) ? (M - 1) : 1;

    localparam logic [M-1:0]  LAST_WCNT = M'(DEPTH - 1);
    localparam logic [RW-1:0] LAST_PAIR = RW'(2**(M-1) - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Storage and state
    logic [W-1:0]  r_mem [DEPTH];
    state_t        r_state;
    logic [M-1:0]  r_wcnt;
    logic [RW-1:0] r_rcnt;
    logic          r_in_ready;
    logic          r_pair_valid;
    logic          r_pair_last;
    logic [W-1:0]  r_pair_a;
    logic [W-1:0]  r_pair_b;

    // Next-state values
    state_t        w_state_nxt;
    logic [M-1:0]  w_wcnt_nxt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_in_ready_nxt;
    logic          w_pair_valid_nxt;
    logic          w_pair_last_nxt;
    logic [W-1:0]  w_pair_a_nxt;
    logic [W-1:0]  w_pair_b_nxt;

    // Datapath helpers
    logic          w_wr_en;
    logic [M-1:0]  w_wr_addr;
    logic          w_adv;
    logic [RW-1:0] w_ld_idx;
    logic [M-1:0]  w_rd_addr_a;
    logic [M-1:0]  w_rd_addr_b;
    logic [W-1:0]  w_mem_a;
    logic [W-1:0]  w_mem_b;

`ifdef FFT_IBUF_BITREV_EN
    function automatic logic [M-1:0] bitrev(input logic [M-1:0] a);
        logic [M-1:0] r;
        for (int i = 0; i < M; i++) begin
            r[i] = a[M-1-i];
        end
        return r;
    endfunction

    assign w_wr_addr = bitrev(r_wcnt);
`else
    assign w_wr_addr = r_wcnt;
`endif

    // A write is gated by rst so a sample presented on the reset edge is not
    // half-accepted into a block that is being discarded anyway.
    assign w_wr_en = rst && (r_state == S_FILL) && in_valid && r_in_ready;

    // Accepting a non-final pair moves the read index on by one; the output
    // registers are then loaded from the new index on the same edge, so
    // pairs stream back to back while pair_ready stays high.
    assign w_adv    = (r_state == S_DRAIN) && r_pair_valid && pair_ready &&
                      (r_rcnt != LAST_PAIR);
    assign w_ld_idx = w_adv ? (r_rcnt + RW'(1)) : r_rcnt;

    // Pair k lives at addresses 2k and 2k+1.
    assign w_rd_addr_a = M'({w_ld_idx, 1'b0});
    assign w_rd_addr_b = M'({w_ld_idx, 1'b1});
    assign w_mem_a     = r_mem[w_rd_addr_a];
    assign w_mem_b     = r_mem[w_rd_addr_b];

    // Next-state and output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_wcnt_nxt       = r_wcnt;
        w_rcnt_nxt       = r_rcnt;
        w_in_ready_nxt   = r_in_ready;
        w_pair_valid_nxt = r_pair_valid;
        w_pair_last_nxt  = r_pair_last;
        w_pair_a_nxt     = r_pair_a;
        w_pair_b_nxt     = r_pair_b;

        case (r_state)
            S_FILL: begin
                // in_ready comes up on the first edge after reset release.
                w_in_ready_nxt = 1'b1;
                if (in_valid && r_in_ready) begin
                    // Wraps to 0 on the final sample of the block.
                    w_wcnt_nxt = r_wcnt + M'(1);
                    if (r_wcnt == LAST_WCNT) begin
                        w_in_ready_nxt = 1'b0;
                        w_state_nxt    = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                w_in_ready_nxt = 1'b0;
                if (!r_pair_valid) begin
                    // First edge in DRAIN: present pair 0.
                    w_pair_valid_nxt = 1'b1;
                    w_pair_a_nxt     = w_mem_a;
                    w_pair_b_nxt     = w_mem_b;
                    w_pair_last_nxt  = (w_ld_idx == LAST_PAIR);
                end else if (pair_ready) begin
                    if (r_rcnt == LAST_PAIR) begin
                        w_pair_valid_nxt = 1'b0;
                        w_pair_last_nxt  = 1'b0;
                        w_in_ready_nxt   = 1'b1;
                        w_rcnt_nxt       = '0;
                        w_state_nxt      = S_FILL;
                    end else begin
                        w_rcnt_nxt      = w_ld_idx;
                        w_pair_a_nxt    = w_mem_a;
                        w_pair_b_nxt    = w_mem_b;
                        w_pair_last_nxt = (w_ld_idx == LAST_PAIR);
                    end
                end
                // pair_valid && !pair_ready: everything holds.
            end

            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_FILL;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_in_ready   <= 1'b0;
            r_pair_valid <= 1'b0;
            r_pair_last  <= 1'b0;
            r_pair_a     <= '0;
            r_pair_b     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_pair_valid <= w_pair_valid_nxt;
            r_pair_last  <= w_pair_last_nxt;
            r_pair_a     <= w_pair_a_nxt;
            r_pair_b     <= w_pair_b_nxt;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= in_data;
        end
    end

    assign in_ready    = r_in_ready;
    assign pair_a      = r_pair_a;
    assign pair_b      = r_pair_b;
    assign pair_valid  = r_pair_valid;
    assign pair_last   = r_pair_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fft_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_input_buffer
//
// Directed bench for fft_input_buffer with N = 4 (16-bit data), M = 3
// (8-sample blocks, 4 pairs). Expected pairs come from a hand-written index
// table for the build in use, pushed into an expected queue when a block is
// filled and popped as pairs are drained.
// ---------------------------------------------------------------------------
module tb_fft_input_buffer;

    localparam int N = 4;
    localparam int M = 3;
    localparam int W = 2**N;

    typedef logic [W-1:0] blk_t [8];

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] pair_a;
    logic [W-1:0] pair_b;
    logic         pair_valid;
    logic         pair_ready;
    logic         pair_last;
    logic         dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fft_input_buffer #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pair_a      (pair_a),
        .pair_b      (pair_b),
        .pair_valid  (pair_valid),
        .pair_ready  (pair_ready),
        .pair_last   (pair_last),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Sample index feeding operand a / b of pair k.
`ifdef FFT_IBUF_BITREV_EN
    int idx_a [4] = '{0, 2, 1, 3};
    int idx_b [4] = '{4, 6, 5, 7};
`else
    int idx_a [4] = '{0, 2, 4, 6};
    int idx_b [4] = '{1, 3, 5, 7};
`endif

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic feed_sample(input logic [W-1:0] d);
        int cyc;
        in_data  = d;
        in_valid = 1'b1;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic fill_block(input blk_t s, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                in_valid = 1'b0;
                in_data  = 16'hBAD0;
                repeat (g) step();
            end
            feed_sample(s[i]);
            if (i < 7) begin
                n_checks++;
                if (in_ready !== 1'b1 || pair_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_progress[%0d]: in_ready=%b pair_valid=%b required 1/0",
                             i, in_ready, pair_valid);
                end
            end
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if (pair_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done_valid: got %b expected 0", pair_valid);
        end
        n_checks++;
        if (dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_done_state: got %b expected 1", dbg_state);
        end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(s[idx_a[k]]);
            exp_q.push_back(s[idx_b[k]]);
        end
    endtask

    task automatic check_pair(input string tag, input int k,
                              input logic [W-1:0] ea, input logic [W-1:0] eb);
        n_checks++;
        if (pair_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid[%0d]: got %b expected 1", tag, k, pair_valid);
        end
        n_checks++;
        if (pair_a !== ea) begin
            n_fail++;
            $display("FAIL %s_a[%0d]: got %h expected %h", tag, k, pair_a, ea);
        end
        n_checks++;
        if (pair_b !== eb) begin
            n_fail++;
            $display("FAIL %s_b[%0d]: got %h expected %h", tag, k, pair_b, eb);
        end
        n_checks++;
        if (pair_last !== (k == 3)) begin
            n_fail++;
            $display("FAIL %s_last[%0d]: got %b expected %b", tag, k, pair_last, (k == 3));
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_in_ready[%0d]: got %b expected 0", tag, k, in_ready);
        end
    endtask

    // Called right after the edge that took the last sample. The first pair
    // must appear after exactly one more edge.
    task automatic drain_block(input int stall_pair, input int stall_cycles, input bit poke);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        pair_ready = 1'b1;
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 16'hDEAD;
        end
        step();
        for (int k = 0; k < 4; k++) begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            if (k == stall_pair) begin
                pair_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check_pair("stall", k, ea, eb);
                    step();
                end
                pair_ready = 1'b1;
            end
            check_pair("drain", k, ea, eb);
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (pair_valid !== 1'b0 || pair_last !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end_valid: pair_valid=%b pair_last=%b required 0/0",
                     pair_valid, pair_last);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end_ready: got %b expected 1", in_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b0;
        in_valid   = 1'b1;
        in_data    = 16'h1234;
        pair_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (in_ready !== 1'b0 || pair_valid !== 1'b0 || pair_last !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: in_ready=%b pair_valid=%b pair_last=%b required 0/0/0",
                         c, in_ready, pair_valid, pair_last);
            end
            n_checks++;
            if (pair_a !== 16'h0000 || pair_b !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: a=%h b=%h required 0000/0000", c, pair_a, pair_b);
            end
            n_checks++;
            if (dbg_state !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %b expected 0", c, dbg_state);
            end
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_drain();
        blk_t s = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17};
        fill_block(s, 1'b0);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        blk_t s = '{16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27};
        fill_block(s, 1'b0);
        drain_block(1, 3, 1'b1);
    endtask

    task automatic test_input_gaps();
        blk_t s = '{16'd30, 16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 16'd36, 16'd37};
        fill_block(s, 1'b1);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        blk_t s = '{16'h0060, 16'h0061, 16'h0062, 16'h0063,
                    16'h0064, 16'h0065, 16'h0066, 16'h0067};
        for (int i = 0; i < 5; i++) feed_sample(16'h0050 + 16'(i));
        rst = 1'b0;
        step();
        n_checks++;
        if (pair_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fill_hold: pair_valid=%b in_ready=%b required 0/0", pair_valid, in_ready);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (pair_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fill_release: pair_valid=%b in_ready=%b required 0/1", pair_valid, in_ready);
        end
        fill_block(s, 1'b0);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        blk_t s  = '{16'h0070, 16'h0071, 16'h0072, 16'h0073,
                     16'h0074, 16'h0075, 16'h0076, 16'h0077};
        blk_t s2 = '{16'h0080, 16'h0081, 16'h0082, 16'h0083,
                     16'h0084, 16'h0085, 16'h0086, 16'h0087};
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        fill_block(s, 1'b0);
        pair_ready = 1'b1;
        step();   // pair 0 shown
        step();   // pair 1 shown
        step();   // pair 2 shown
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        check_pair("mid", 2, ea, eb);
        rst = 1'b0;
        step();
        n_checks++;
        if (pair_valid !== 1'b0 || pair_last !== 1'b0 || pair_a !== 16'h0 || pair_b !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_drain_clear: valid=%b last=%b a=%h b=%h required 0/0/0000/0000",
                     pair_valid, pair_last, pair_a, pair_b);
        end
        n_checks++;
        if (in_ready !== 1'b0 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drain_ctrl: in_ready=%b state=%b required 0/0", in_ready, dbg_state);
        end
        exp_q.delete();
        rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_drain_release: got %b expected 1", in_ready);
        end
        fill_block(s2, 1'b0);
        drain_block(-1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        blk_t s1 = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                     16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        blk_t s2 = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF,
                     16'h8000, 16'h7FFF, 16'h0000, 16'h8001};
        fill_block(s1, 1'b0);
        drain_block(-1, 0, 1'b0);
        fill_block(s2, 1'b0);
        drain_block(-1, 0, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst        = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        pair_ready = 1'b0;
        test_reset();
        test_drain();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_fill();
        test_reset_mid_drain();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
